// File: rtl/moller_regs_axil_master.sv
// Command/response to single-beat AXI4-Lite initiator for the moller register map.
// Optional per-transaction slave timeout is enabled by defining MOLLER_AXIL_TIMEOUT_EN.
module moller_regs_axil_master #(
  parameter logic [31:0] BASEADDR       = 32'h8000_0000,
  parameter int unsigned RANGE_BYTES    = 276,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic [31:0] m_axi_awaddr,
  output logic [2:0]  m_axi_awprot,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RESP} state_t;

  localparam logic [31:0] LAST_OFF = 32'(RANGE_BYTES - 4);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_hs, w_hs;
  logic        timeout;
  logic        unused_resp_lsb;

  // Only the error bit of BRESP/RRESP matters: SLVERR and DECERR map to the same code.
  assign unused_resp_lsb = ^{m_axi_bresp[0], m_axi_rresp[0]};

  assign cmd_ready     = (state_q == IDLE) && axi_aresetn;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_err       = err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_awvalid = (state_q == WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == WR) && !w_done_q;
  assign m_axi_bready  = (state_q == WB);
  assign m_axi_arvalid = (state_q == RA);
  assign m_axi_rready  = (state_q == RD);

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;

`ifdef MOLLER_AXIL_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        busy;

  assign busy    = (state_q == WR) || (state_q == WB) || (state_q == RA) || (state_q == RD);
  assign timeout = busy && (tmo_cnt_q == TMO_LAST);

  // Every bus phase is entered from IDLE, so clearing there clears on entry to WR/RA.
  always_comb begin
    tmo_cnt_d = 32'd0;
    if (busy) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) tmo_cnt_q <= 32'd0;
    else              tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo;
  assign timeout    = 1'b0;
  assign unused_tmo = ^TMO_LAST;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wdata_d   = cmd_wdata;
          rdata_d   = 32'd0;
          err_d     = 2'b00;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if ((cmd_addr[1:0] != 2'b00) || (cmd_addr > LAST_OFF)) begin
            err_d   = 2'b10;
            state_d = RESP;
          end else begin
            addr_d  = BASEADDR + cmd_addr;
            state_d = cmd_write ? WR : RA;
          end
        end
      end
      WR: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = WB;
      end
      WB: begin
        if (m_axi_bvalid) begin
          err_d   = m_axi_bresp[1] ? 2'b01 : 2'b00;
          state_d = RESP;
        end
      end
      RA: begin
        if (m_axi_arready) state_d = RD;
      end
      RD: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rresp[1] ? 32'd0 : m_axi_rdata;
          err_d   = m_axi_rresp[1] ? 2'b01 : 2'b00;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A timeout wins over any handshake landing in the same cycle.
    if (timeout) begin
      state_d = RESP;
      err_d   = 2'b11;
      rdata_d = 32'd0;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 2'b00;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_moller_regs_axil_master.sv
// Directed bench for moller_regs_axil_master with a small configurable AXI4-Lite slave.
module tb_moller_regs_axil_master;

  logic        clk = 1'b0;
  logic        axi_aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0, cmd_wdata = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp_k = 2'b00, rresp_k = 2'b00;
  logic [31:0] rdata_k = 32'd0;

  // slave controls and observations
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic        ar_block = 1'b0, r_block = 1'b0;
  logic        aw_fire = 1'b0, w_fire = 1'b0, b_fire = 1'b0, ar_fire = 1'b0, r_fire = 1'b0;
  logic        aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;
  int          awv_cycles = 0, wv_cycles = 0, arv_cycles = 0, b_count = 0;
  logic [31:0] last_awaddr = 32'd0, last_wdata = 32'd0, last_araddr = 32'd0;
  logic [3:0]  last_wstrb = 4'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  moller_regs_axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .axi_aclk(clk), .axi_aresetn(axi_aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp_k), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata_k), .m_axi_rresp(rresp_k), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // Slave works on the falling edge: it commits handshakes from the previous rising
  // edge, then sets readies/valids for the next one.
  always @(negedge clk) begin
    if (!axi_aresetn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_seen = 0; w_seen = 0; ar_seen = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (aw_fire) aw_seen = 1;
      if (w_fire) w_seen = 1;
      if (b_fire) begin bvalid = 0; b_count++; end
      if (ar_fire) ar_seen = 1;
      if (r_fire) rvalid = 0;
      if (aw_seen && w_seen && !bvalid) begin bvalid = 1; aw_seen = 0; w_seen = 0; end
      if (ar_seen && !rvalid && !r_block) begin rvalid = 1; ar_seen = 0; end
      awready = awvalid && (aw_cnt >= aw_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      wready  = wvalid && (w_cnt >= w_delay);
      w_cnt   = wvalid ? w_cnt + 1 : 0;
      arready = arvalid && !ar_block;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (aw_fire) last_awaddr = awaddr;
      if (w_fire) begin last_wdata = wdata; last_wstrb = wstrb; end
      if (ar_fire) last_araddr = araddr;
      if (awvalid) awv_cycles++;
      if (wvalid) wv_cycles++;
      if (arvalid) arv_cycles++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Present a command and return at the falling edge after its handshake edge.
  task automatic send(input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check("cmd_accepted", 32'(n < 50), 32'd1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  // lat = cycle after the handshake cycle in which rsp_valid is seen; maxw+1 if never.
  task automatic wait_rsp(input int maxw, output int lat);
    lat = 1;
    while (!rsp_valid && lat <= maxw) begin @(negedge clk); lat++; end
  endtask

  task automatic consume();
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    int lat, awv0, wv0, arv0, b0;
    logic [31:0] hold_rdata;

    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_bus_valids", {27'd0, awvalid, wvalid, bready, arvalid, rready}, 32'd0);
    check("rst_rsp_data", rsp_rdata | 32'(rsp_err), 32'd0);
    axi_aresetn = 1;
    @(negedge clk);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // zero-wait write
    send(1'b1, 32'h48, 32'h80FF_0010);
    wait_rsp(50, lat);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_err", 32'(rsp_err), 32'd0);
    check("wr_rdata", rsp_rdata, 32'd0);
    check("wr_awaddr", last_awaddr, 32'h8000_0048);
    check("wr_wdata", last_wdata, 32'h80FF_0010);
    check("wr_wstrb", 32'(last_wstrb), 32'hF);
    check("prot", {26'd0, awprot, arprot}, 32'd0);
    check("resp_cmd_ready", 32'(cmd_ready), 32'd0);
    consume();

    // zero-wait read
    rdata_k = 32'h0000_011F; rresp_k = 2'b00;
    send(1'b0, 32'h40, 32'd0);
    wait_rsp(50, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rsp_rdata, 32'h0000_011F);
    check("rd_err", 32'(rsp_err), 32'd0);
    check("rd_araddr", last_araddr, 32'h8000_0040);
    consume();

    // rejects: out of range and misaligned; no bus activity
    awv0 = awv_cycles; wv0 = wv_cycles; arv0 = arv_cycles;
    send(1'b0, 32'h114, 32'd0);
    wait_rsp(50, lat);
    check("rej_range_latency", 32'(lat), 32'd1);
    check("rej_range_err", 32'(rsp_err), 32'd2);
    check("rej_range_rdata", rsp_rdata, 32'd0);
    consume();
    send(1'b1, 32'h4A, 32'h1234_5678);
    wait_rsp(50, lat);
    check("rej_align_latency", 32'(lat), 32'd1);
    check("rej_align_err", 32'(rsp_err), 32'd2);
    consume();
    check("rej_no_bus", 32'((awv_cycles - awv0) + (wv_cycles - wv0) + (arv_cycles - arv0)), 32'd0);

    // last valid offset
    rdata_k = 32'hCAFE_0110;
    send(1'b0, 32'h110, 32'd0);
    wait_rsp(50, lat);
    check("edge_latency", 32'(lat), 32'd3);
    check("edge_araddr", last_araddr, 32'h8000_0110);
    check("edge_rdata", rsp_rdata, 32'hCAFE_0110);
    consume();

    // awready delayed, wready immediate
    aw_delay = 4; w_delay = 0;
    awv0 = awv_cycles; wv0 = wv_cycles; b0 = b_count;
    send(1'b1, 32'h10, 32'hDEAD_BEEF);
    wait_rsp(50, lat);
    check("slow_aw_latency", 32'(lat), 32'd7);
    check("slow_aw_awvalid_cycles", 32'(awv_cycles - awv0), 32'd5);
    check("slow_aw_wvalid_cycles", 32'(wv_cycles - wv0), 32'd1);
    check("slow_aw_err", 32'(rsp_err), 32'd0);
    consume();
    check("slow_aw_b_count", 32'(b_count - b0), 32'd1);

    // wready delayed, awready immediate, SLVERR
    aw_delay = 0; w_delay = 2; bresp_k = 2'b10;
    send(1'b1, 32'h14, 32'h0000_0001);
    wait_rsp(50, lat);
    check("slverr_latency", 32'(lat), 32'd5);
    check("slverr_err", 32'(rsp_err), 32'd1);
    consume();
    w_delay = 0; bresp_k = 2'b11;
    send(1'b1, 32'h18, 32'h0000_0002);
    wait_rsp(50, lat);
    check("decerr_err", 32'(rsp_err), 32'd1);
    consume();
    bresp_k = 2'b00;

    // read error forces rdata to zero
    rdata_k = 32'h5555_AAAA; rresp_k = 2'b10;
    send(1'b0, 32'h20, 32'd0);
    wait_rsp(50, lat);
    check("rd_slverr_rdata", rsp_rdata, 32'd0);
    check("rd_slverr_err", 32'(rsp_err), 32'd1);
    consume();
    rresp_k = 2'b00;

    // response backpressure with a new command pending
    rdata_k = 32'hA5A5_0001;
    send(1'b0, 32'h0, 32'd0);
    wait_rsp(50, lat);
    hold_rdata = rsp_rdata;
    check("stall_rdata", hold_rdata, 32'hA5A5_0001);
    rdata_k = 32'h0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'h0000_0044;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_rdata", rsp_rdata, hold_rdata);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    consume();
    check("after_stall_cmd_ready", 32'(cmd_ready), 32'd1);
    send(1'b1, 32'h4, 32'h0000_0044);
    wait_rsp(50, lat);
    check("after_stall_latency", 32'(lat), 32'd3);
    check("after_stall_awaddr", last_awaddr, 32'h8000_0004);
    consume();

    // reset while waiting in RD
    r_block = 1;
    send(1'b0, 32'h8, 32'd0);
    lat = 0;
    while (!rready && lat < 20) begin @(negedge clk); lat++; end
    check("in_rd", 32'(rready), 32'd1);
    axi_aresetn = 0;
    @(negedge clk);
    check("midrst_ctrl", {27'd0, cmd_ready, rsp_valid, awvalid, wvalid, arvalid}, 32'd0);
    check("midrst_ready", {30'd0, bready, rready}, 32'd0);
    check("midrst_addr", awaddr | araddr | wdata, 32'd0);
    check("midrst_rsp", rsp_rdata | 32'(rsp_err), 32'd0);
    axi_aresetn = 1;
    @(negedge clk);
    r_block = 0;
    repeat (5) @(negedge clk);
    check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    check("midrst_idle", 32'(cmd_ready), 32'd1);

    // slave never accepts AR
    ar_block = 1;
    send(1'b0, 32'hC, 32'd0);
`ifdef MOLLER_AXIL_TIMEOUT_EN
    wait_rsp(100, lat);
    check("tmo_latency", 32'(lat), 32'd17);
    check("tmo_err", 32'(rsp_err), 32'd3);
    check("tmo_rdata", rsp_rdata, 32'd0);
    check("tmo_arvalid", 32'(arvalid), 32'd0);
    consume();
    ar_block = 0;
`else
    wait_rsp(1000, lat);
    check("no_tmo_still_waiting", 32'(lat), 32'd1001);
    check("no_tmo_arvalid", 32'(arvalid), 32'd1);
    axi_aresetn = 0;
    @(negedge clk);
    axi_aresetn = 1;
    ar_block = 0;
    @(negedge clk);
    check("no_tmo_recovered", 32'(cmd_ready), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
